word_narrow: RTL

Narrowing encoder for the 32-bit datapath: accepts 32-bit words and emits them on a 16-bit bus as one beat when the word is a sign-extended 16-bit value, or as two beats (high half, then low half) otherwise. It is the sending end of the existing 16-to-32 sign-extend path; the receiver rebuilds the word by sign-extending single-beat values and concatenating two-beat values. It sits between the register-file read port and the 16-bit immediate/memory bus, with valid/ready handshakes on both sides.

---
 rtl/word_narrow_pkg.sv | 21 ++
 rtl/word_narrow_if.sv | 29 ++
 rtl/word_narrow_sext_fit_check.sv | 16 +
 rtl/word_narrow.sv | 110 +++++++++++
 4 files changed

// File: rtl/word_narrow_pkg.sv
// Shared types and helpers for the 32-to-16 narrowing encoder.
package narrow_pkg;

  localparam int DEF_WIDE   = 32;
  localparam int DEF_NARROW = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_ONE = 2'd1,
    SEND_HI  = 2'd2,
    SEND_LO  = 2'd3
  } state_t;

  // A word fits one beat when every bit from the narrow sign bit upward is equal.
  function automatic logic fits_sext(input logic [DEF_WIDE-1:0] word);
    logic [DEF_WIDE-DEF_NARROW:0] top_bits;
    top_bits = word[DEF_WIDE-1:DEF_NARROW-1];
    return (&top_bits) | ~(|top_bits);
  endfunction

endpackage

// File: rtl/word_narrow_if.sv
// Word input stream and beat output stream of the narrowing encoder.
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both 1. A source holds valid and its payload stable until that transfer;
// ready may depend combinationally on valid.
interface word_narrow_if #(
  parameter int WIDE   = 32,
  parameter int NARROW = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDE-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [NARROW-1:0] out_data;
  logic              out_short;
  logic              out_last;

  // The encoder itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_short, out_last
  );

  // Word producer and beat consumer around the encoder.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_short, out_last
  );
endinterface

// File: rtl/word_narrow_sext_fit_check.sv
// Combinational test: does a wide word survive truncation to NARROW bits
// followed by sign extension back to WIDE bits.
module sext_fit_check
  import narrow_pkg::*;
#(
  parameter int WIDE   = DEF_WIDE,
  parameter int NARROW = DEF_NARROW
) (
  input  logic [WIDE-1:0] word,
  output logic            fits
);
  logic [WIDE-NARROW:0] top_bits;

  assign top_bits = word[WIDE-1:NARROW-1];
  assign fits     = (&top_bits) | ~(|top_bits);
endmodule

// File: rtl/word_narrow.sv
// Narrowing encoder: sends each 32-bit word as one sign-extendable beat or as
// a high beat followed by a low beat. WIDE must equal 2*NARROW.
module word_narrow
  import narrow_pkg::*;
#(
  parameter int WIDE   = DEF_WIDE,
  parameter int NARROW = DEF_NARROW,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  word_narrow_if.slave     bus,
  output logic [CNT_W-1:0] short_cnt,
  output logic [CNT_W-1:0] long_cnt,
  output state_t           dbg_state
);

  state_t            state;
  state_t            state_nxt;
  logic [WIDE-1:0]   word;
  logic              in_fits;
  logic              accept;
  logic              last_fire;
  logic              beat_valid;
  logic              beat_short;
  logic              beat_last;
  logic [NARROW-1:0] beat_data;

  sext_fit_check #(.WIDE(WIDE), .NARROW(NARROW)) u_fit (
    .word (bus.in_data),
    .fits (in_fits)
  );

  // Beat outputs are a pure decode of the state and the latched word, so they
  // stay stable for as long as the state is held waiting for out_ready.
  always_comb begin
    beat_valid = 1'b0;
    beat_short = 1'b0;
    beat_last  = 1'b0;
    beat_data  = '0;
    case (state)
      SEND_ONE: begin
        beat_valid = 1'b1;
        beat_short = 1'b1;
        beat_last  = 1'b1;
        beat_data  = word[NARROW-1:0];
      end
      SEND_HI: begin
        beat_valid = 1'b1;
        beat_data  = word[WIDE-1:NARROW];
      end
      SEND_LO: begin
        beat_valid = 1'b1;
        beat_last  = 1'b1;
        beat_data  = word[NARROW-1:0];
      end
      default: ;
    endcase
  end

  // Handshake and next state; finishing a word frees the input in the same
  // cycle so back-to-back words flow without a bubble.
  always_comb begin
    last_fire = beat_valid & bus.out_ready & beat_last;
    bus.in_ready = (state == IDLE) | last_fire;
    accept    = bus.in_valid & bus.in_ready;
    state_nxt = state;
    if (accept) begin
      state_nxt = in_fits ? SEND_ONE : SEND_HI;
    end else if (last_fire) begin
      state_nxt = IDLE;
    end else if ((state == SEND_HI) && bus.out_ready) begin
      state_nxt = SEND_LO;
    end
  end

  assign bus.out_valid = beat_valid;
  assign bus.out_short = beat_short;
  assign bus.out_last  = beat_last;
  assign bus.out_data  = beat_data;
  assign dbg_state     = state;

  // State register and word latch; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      word  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        word <= bus.in_data;
      end
    end
  end

  // Saturating word counters, stepped when a word is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      short_cnt <= '0;
      long_cnt  <= '0;
    end else if (accept) begin
      if (in_fits) begin
        if (short_cnt != {CNT_W{1'b1}}) short_cnt <= short_cnt + 1'b1;
      end else begin
        if (long_cnt != {CNT_W{1'b1}}) long_cnt <= long_cnt + 1'b1;
      end
    end
  end

endmodule
